// File: rtl/key_debounce_irq_if.sv
// Bus bundle between the keypad debouncer and the peripheral register bank.
// There is no valid/ready handshake on this bundle. col is a raw asynchronous
// level. irq_clr is a one-cycle request sampled on HCLK. key_press and
// key_release are one-cycle strobes. key_level, irq_pending and irq are
// registered levels. dbg_state exposes each channel's debounce FSM state.
interface key_debounce_irq_if #(
  parameter int NUM_KEYS = 8
);
  logic [NUM_KEYS-1:0]      col;
  logic [NUM_KEYS-1:0]      irq_mask;
  logic [NUM_KEYS-1:0]      irq_clr;
  logic [NUM_KEYS-1:0]      key_level;
  logic [NUM_KEYS-1:0]      key_press;
  logic [NUM_KEYS-1:0]      key_release;
  logic [NUM_KEYS-1:0]      irq_pending;
  logic                     irq;
  logic [NUM_KEYS-1:0][1:0] dbg_state;

  // Pad and register-bank side.
  modport master (
    output col, irq_mask, irq_clr,
    input  key_level, key_press, key_release, irq_pending, irq, dbg_state
  );

  // Debouncer side.
  modport slave (
    input  col, irq_mask, irq_clr,
    output key_level, key_press, key_release, irq_pending, irq, dbg_state
  );
endinterface

// File: rtl/key_debounce_irq.sv
// Keypad/column debouncer with sticky pending flags and one aggregated IRQ.
// Each channel has a 2-flop synchroniser and a 4-state debounce FSM.
// Press, release and level outputs are registered. Pending bits are set by
// press strobes, and also by release strobes when IRQ_ON_RELEASE=1. A set
// beats a coincident clear.
// Optional macro KEY_AUTOREPEAT_EN adds periodic repeat presses while a key
// stays held.
module key_debounce_irq #(
  parameter int NUM_KEYS         = 8,
  parameter int DEBOUNCE_CYC     = 1048575,
  parameter int CNT_W            = 20,
  parameter int ACTIVE_HIGH      = 1,
  parameter int IRQ_ON_RELEASE   = 0,
  parameter int REPEAT_DELAY_CYC = 500000,
  parameter int REPEAT_CYC       = 100000
) (
  input logic               HCLK,
  input logic               HRESETn,
  key_debounce_irq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Elaboration-time parameter sanity checks.
  if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_bad_num_keys
    $error("NUM_KEYS out of range");
  end
  if (DEBOUNCE_CYC < 1 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYC)) begin : g_bad_cnt
    $error("DEBOUNCE_CYC must be >= 1 and fit in CNT_W bits");
  end
  if (REPEAT_DELAY_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY_CYC and REPEAT_CYC must be >= 1");
  end

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, raw;
  state_e              state_q [NUM_KEYS];
  state_e              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [NUM_KEYS-1:0] rpt_fire;
  logic                irq_q, irq_d;

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.col;
      sync2_q <= sync1_q;
    end
  end

  // Map the pad polarity onto "pressed".
  assign raw = (ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;

  // Debounce FSM next state. A bounce returns to the last stable state.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    level_d   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (raw[i]) begin
            state_d[i] = DB_PRESS;
            cnt_d[i]   = '0;
          end
        end
        DB_PRESS: begin
          if (!raw[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (!raw[i]) begin
            state_d[i] = DB_RELEASE;
            cnt_d[i]   = '0;
          end
        end
        DB_RELEASE: begin
          if (raw[i]) begin
            state_d[i] = HELD;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = IDLE;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      endcase
      level_d[i] = (state_d[i] == HELD) || (state_d[i] == DB_RELEASE);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_CYC) ? REPEAT_DELAY_CYC : REPEAT_CYC;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_CYC - 1);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

  logic [RPT_W-1:0]    rpt_q [NUM_KEYS];
  logic [RPT_W-1:0]    rpt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] armed_q, armed_d;

  // Repeat timer: counts while stably held, frozen during release bounce.
  always_comb begin
    rpt_fire = '0;
    armed_d  = armed_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      rpt_d[i] = rpt_q[i];
      if (state_q[i] == HELD && raw[i]) begin
        if (rpt_q[i] == (armed_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
          rpt_fire[i] = 1'b1;
          rpt_d[i]    = '0;
          armed_d[i]  = 1'b1;
        end else begin
          rpt_d[i] = rpt_q[i] + RPT_ONE;
        end
      end else if (state_q[i] == IDLE || state_q[i] == DB_PRESS) begin
        rpt_d[i]   = '0;
        armed_d[i] = 1'b0;
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      armed_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) rpt_q[i] <= '0;
    end else begin
      armed_q <= armed_d;
      for (int i = 0; i < NUM_KEYS; i++) rpt_q[i] <= rpt_d[i];
    end
  end
`else
  assign rpt_fire = '0;
`endif

  // Pending flags: a set beats a coincident clear; the mask only gates irq.
  always_comb begin
    pend_d = (pend_q & ~bus.irq_clr) | press_q;
    if (IRQ_ON_RELEASE != 0) pend_d = pend_d | release_q;
    irq_d = |(pend_q & bus.irq_mask);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      pend_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d | rpt_fire;
      release_q <= release_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
    end
  end

  // Drive the bundle outputs and the debug state view.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) bus.dbg_state[i] = state_q[i];
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.irq_pending = pend_q;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_key_debounce_irq.sv
// Bench for key_debounce_irq. Two instances share one logical key stream:
// u_dut_a is active-high with IRQ_ON_RELEASE=1. u_dut_b is active-low (it is
// fed ~keys) with IRQ_ON_RELEASE=0. Every cycle both are compared against a
// run-length reference model. A vector table and hand sequences then check
// the exact latencies and corner cases.
module tb_key_debounce_irq;
  localparam int NK = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RC = 5;

  logic clk, rst_n;
  logic [NK-1:0] keys, mask, clr;

  key_debounce_irq_if #(.NUM_KEYS(NK)) bus_a ();
  key_debounce_irq_if #(.NUM_KEYS(NK)) bus_b ();

  assign bus_a.col      = keys;
  assign bus_a.irq_mask = mask;
  assign bus_a.irq_clr  = clr;
  assign bus_b.col      = ~keys;
  assign bus_b.irq_mask = mask;
  assign bus_b.irq_clr  = clr;

  key_debounce_irq #(.NUM_KEYS(NK), .DEBOUNCE_CYC(D), .CNT_W(4), .ACTIVE_HIGH(1),
    .IRQ_ON_RELEASE(1), .REPEAT_DELAY_CYC(RD), .REPEAT_CYC(RC))
    u_dut_a (.HCLK(clk), .HRESETn(rst_n), .bus(bus_a));

  key_debounce_irq #(.NUM_KEYS(NK), .DEBOUNCE_CYC(D), .CNT_W(4), .ACTIVE_HIGH(0),
    .IRQ_ON_RELEASE(0), .REPEAT_DELAY_CYC(RD), .REPEAT_CYC(RC))
    u_dut_b (.HCLK(clk), .HRESETn(rst_n), .bus(bus_b));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int press_cnt [NK];
  int rel_cnt   [NK];

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A key changes its debounced level once D+1 consecutive synchronised
  // samples disagree with it; the synchroniser delays each sample by 2 edges.
  logic [NK-1:0] m_lvl, m_s1, m_s2, m_press, m_rel, m_pend_a, m_pend_b;
  logic          m_irq_a, m_irq_b;
  int            m_run [NK];
  int            m_rpt [NK];
  bit            m_armed [NK];

  task automatic model_reset();
    m_lvl = '0; m_s1 = '0; m_s2 = '0; m_press = '0; m_rel = '0;
    m_pend_a = '0; m_pend_b = '0; m_irq_a = 1'b0; m_irq_b = 1'b0;
    for (int i = 0; i < NK; i++) begin
      m_run[i] = 0; m_rpt[i] = 0; m_armed[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [NK-1:0] use_v, press_n, rel_n;
    use_v = m_s2;
    m_s2  = m_s1;
    m_s1  = keys;
    m_irq_a  = |(m_pend_a & mask);
    m_irq_b  = |(m_pend_b & mask);
    m_pend_a = (m_pend_a & ~clr) | m_press | m_rel;
    m_pend_b = (m_pend_b & ~clr) | m_press;
    press_n = '0;
    rel_n   = '0;
    for (int i = 0; i < NK; i++) begin
      if (use_v[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_lvl[i] = use_v[i];
          m_run[i] = 0;
          m_rpt[i] = 0;
          m_armed[i] = 1'b0;
          if (use_v[i]) press_n[i] = 1'b1;
          else          rel_n[i]   = 1'b1;
        end
      end else begin
`ifdef KEY_AUTOREPEAT_EN
        if (m_lvl[i] && m_run[i] == 0) begin
          m_rpt[i]++;
          if (m_rpt[i] == (m_armed[i] ? RC : RD)) begin
            press_n[i] = 1'b1;
            m_rpt[i]   = 0;
            m_armed[i] = 1'b1;
          end
        end
`endif
        m_run[i] = 0;
      end
    end
    m_press = press_n;
    m_rel   = rel_n;
  endtask

  task automatic compare_all();
    chk("level_a",   bus_a.key_level,   m_lvl);
    chk("press_a",   bus_a.key_press,   m_press);
    chk("release_a", bus_a.key_release, m_rel);
    chk("pending_a", bus_a.irq_pending, m_pend_a);
    chk("irq_a",     NK'(bus_a.irq),    NK'(m_irq_a));
    chk("level_b",   bus_b.key_level,   m_lvl);
    chk("press_b",   bus_b.key_press,   m_press);
    chk("release_b", bus_b.key_release, m_rel);
    chk("pending_b", bus_b.irq_pending, m_pend_b);
    chk("irq_b",     NK'(bus_b.irq),    NK'(m_irq_b));
  endtask

  // ---------------- driver ----------------
  // One clock: sample just after the edge, advance the model, compare.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    if (!rst_n) model_reset();
    else        model_edge();
    compare_all();
    for (int i = 0; i < NK; i++) begin
      if (bus_a.key_press[i])   press_cnt[i]++;
      if (bus_a.key_release[i]) rel_cnt[i]++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0;
    end
  endtask

  task automatic clear_all_pending();
    clr = '1; step(); clr = '0; run(2);
  endtask

  typedef struct {
    logic [NK-1:0] keys, mask, clr;
    int            n;
    logic [NK-1:0] lvl, pa, pb;
    logic          ia, ib;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int e, first_press, first_lvl, first_pend, first_irq, found;

    tbl[0]  = '{4'h0, 4'hF, 4'h0,  4, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{4'h1, 4'hF, 4'h0, 15, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1};
    tbl[2]  = '{4'h1, 4'hF, 4'hF,  1, 4'h1, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[3]  = '{4'h1, 4'hF, 4'h0,  1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{4'h0, 4'hF, 4'h0, 15, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[5]  = '{4'h0, 4'h0, 4'hF,  2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[6]  = '{4'h4, 4'hB, 4'h0, 15, 4'h4, 4'h4, 4'h4, 1'b0, 1'b0};
    tbl[7]  = '{4'h4, 4'hF, 4'h0,  1, 4'h4, 4'h4, 4'h4, 1'b1, 1'b1};
    tbl[8]  = '{4'h0, 4'hF, 4'h4,  1, 4'h4, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[9]  = '{4'h0, 4'hF, 4'h0, 15, 4'h0, 4'h4, 4'h0, 1'b1, 1'b0};
    tbl[10] = '{4'h0, 4'hF, 4'hF,  2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};

    // ---- reset ----
    rst_n = 1'b0; keys = '0; mask = '1; clr = '0;
    model_reset();
    clear_counts();
    #12;
    chk("rst_level",   bus_a.key_level | bus_b.key_level, '0);
    chk("rst_press",   bus_a.key_press | bus_b.key_press, '0);
    chk("rst_pending", bus_a.irq_pending | bus_b.irq_pending, '0);
    chk("rst_irq",     NK'(bus_a.irq | bus_b.irq), '0);
    run(2);
    rst_n = 1'b1;
    run(4);

    // ---- exact press latency on channel 0 ----
    keys[0] = 1'b1;
    first_press = 0; first_lvl = 0; first_pend = 0; first_irq = 0;
    clear_counts();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first_press == 0 && bus_a.key_press[0] && bus_b.key_press[0]) first_press = k;
      if (first_lvl == 0 && bus_a.key_level[0]) first_lvl = k;
      if (first_pend == 0 && bus_a.irq_pending[0]) first_pend = k;
      if (first_irq == 0 && bus_a.irq) first_irq = k;
    end
    chk_int("press_edge", first_press, D + 3);
    chk_int("level_edge", first_lvl, D + 3);
    chk_int("pend_edge", first_pend, D + 4);
    chk_int("irq_edge", first_irq, D + 5);
    chk_int("press_once", press_cnt[0], 1);

    // ---- bouncy press on channel 1 ----
    keys = '0;
    run(20);
    clear_counts();
    for (int b = 0; b < 6; b++) begin
      keys[1] = 1'b1; run(5);
      keys[1] = 1'b0; run(5);
    end
    chk_int("burst_no_press", press_cnt[1], 0);
    keys[1] = 1'b1;
    e = 0;
    for (int k = 1; k <= 30 && e == 0; k++) begin
      step();
      if (bus_a.key_press[1]) e = k;
    end
    chk_int("burst_press_edge", e, D + 3);
    run(5);
    chk_int("burst_one_press", press_cnt[1], 1);

    // ---- release glitch, then a real release ----
    clear_counts();
    keys[1] = 1'b0; run(3);
    keys[1] = 1'b1; run(25);
    chk_int("glitch_no_release", rel_cnt[1], 0);
    clear_all_pending();
    keys[1] = 1'b0; run(20);
    chk_int("release_pulse", rel_cnt[1], 1);
    chk("release_pend_a", NK'(bus_a.irq_pending[1]), NK'(1));
    chk("release_pend_b", NK'(bus_b.irq_pending[1]), NK'(0));

    // ---- clear coincident with a new press keeps the flag ----
    clear_all_pending();
    keys[2] = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      step();
      if (bus_a.key_press[2]) found = 1;
    end
    chk_int("ch2_press_seen", found, 1);
    clr = 4'h4; step(); clr = '0;
    chk("set_wins_a", NK'(bus_a.irq_pending[2]), NK'(1));
    chk("set_wins_b", NK'(bus_b.irq_pending[2]), NK'(1));
    clr = '1; step(); clr = '0;
    chk("clr_pend_a", bus_a.irq_pending, '0);
    step();
    chk("clr_irq", NK'(bus_a.irq | bus_b.irq), '0);

    // ---- vector table ----
    keys = '0;
    run(20);
    clear_all_pending();
    for (int t = 0; t < 11; t++) begin
      keys = tbl[t].keys; mask = tbl[t].mask; clr = tbl[t].clr;
      run(tbl[t].n);
      clr = '0;
      chk($sformatf("tbl%0d_level", t), bus_a.key_level, tbl[t].lvl);
      chk($sformatf("tbl%0d_level_b", t), bus_b.key_level, tbl[t].lvl);
      chk($sformatf("tbl%0d_pend_a", t), bus_a.irq_pending, tbl[t].pa);
      chk($sformatf("tbl%0d_pend_b", t), bus_b.irq_pending, tbl[t].pb);
      chk($sformatf("tbl%0d_irq_a", t), NK'(bus_a.irq), NK'(tbl[t].ia));
      chk($sformatf("tbl%0d_irq_b", t), NK'(bus_b.irq), NK'(tbl[t].ib));
    end

    // ---- async reset during a press debounce on channel 3 ----
    keys = 4'h4; run(20);
    keys[3] = 1'b1; run(6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", bus_a.key_level | bus_b.key_level, '0);
    chk("async_rst_press", bus_a.key_press | bus_b.key_press, '0);
    keys = '0;
    run(3);
    rst_n = 1'b1;
    clear_counts();
    run(25);
    chk_int("post_rst_no_press", press_cnt[3] + press_cnt[2], 0);
    chk("post_rst_level", bus_a.key_level, '0);

    // ---- long hold on channel 0 ----
    keys[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      step();
      if (bus_a.key_press[0]) found = 1;
    end
    chk_int("hold_press_seen", found, 1);
    clear_counts();
    run(40);
`ifdef KEY_AUTOREPEAT_EN
    chk_int("hold_repeat_count", press_cnt[0], 5);
`else
    chk_int("hold_repeat_count", press_cnt[0], 0);
`endif
    keys = '0;
    run(20);
    clear_all_pending();

    // ---- randomized stimulus against the model ----
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 11) == 0) keys[i] = ~keys[i];
      clr = ($urandom_range(0, 7) == 0) ? NK'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 31) == 0) mask = NK'($urandom_range(0, 15));
      step();
    end
    clr = '0;
    keys = '0;
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
